// File: rtl/stop_watch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// The optional lap feature is enabled with STOP_WATCH_CTRL_LAP_EN.
package stop_watch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stop_watch_ctrl_if.sv
// Controller <-> stopwatch datapath / display mux signal bundle.
// Lap outputs are tied to zero unless STOP_WATCH_CTRL_LAP_EN is defined.
interface stop_watch_ctrl_if;
    logic [3:0] d2, d1, d0;
    logic       go;
    logic       clr;
    logic [3:0] lap_d2, lap_d1, lap_d0;
    logic       lap_valid;
    logic [1:0] state;

    modport master (
        input  d2, d1, d0,
        output go, clr, lap_d2, lap_d1, lap_d0, lap_valid, state
    );

    modport slave (
        output d2, d1, d0,
        input  go, clr, lap_d2, lap_d1, lap_d0, lap_valid, state
    );
endinterface

// File: rtl/stop_watch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
// Used for every button of the stopwatch controller (lap only with STOP_WATCH_CTRL_LAP_EN).
module btn_debounce #(
    parameter int unsigned DB_TICKS = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise_p
);
    localparam int unsigned CW = (DB_TICKS > 2) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    // cnt is the run length of synchronized samples that disagree with level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            rise_p <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            rise_p <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level  <= sync2;
                rise_p <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control FSM: debounced buttons drive go/clr, auto-stop at 999, lap capture.
// Lap logic is built only when STOP_WATCH_CTRL_LAP_EN is defined.
module stop_watch_ctrl
    import stop_watch_pkg::*;
#(
    parameter int unsigned DB_TICKS = 500000,
    parameter bit          MAX_STOP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_go,
    input  logic              btn_clr,
    input  logic              btn_lap,
    stop_watch_ctrl_if.master dp
);
    state_t state_q, state_d;
    logic   go_q, clr_q;
    logic   go_p, clr_p;
    logic   unused_go_level, unused_clr_level;
    logic   at_max;

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_go (
        .clk(clk), .reset(reset), .btn_raw(btn_go),
        .level(unused_go_level), .rise_p(go_p)
    );

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_clr (
        .clk(clk), .reset(reset), .btn_raw(btn_clr),
        .level(unused_clr_level), .rise_p(clr_p)
    );

    assign at_max = (dp.d2 == BCD_MAX) && (dp.d1 == BCD_MAX) && (dp.d0 == BCD_MAX);

    // clear dominates; in RUN a start/stop press outranks the 999 auto-stop
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (go_p) state_d = RUN;
                RUN:     if (go_p) state_d = PAUSE;
                         else if (MAX_STOP && at_max) state_d = DONE;
                PAUSE:   if (go_p) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= (state_d == RUN);
            clr_q   <= clr_p;
        end
    end

    assign dp.state = state_q;
    assign dp.go    = go_q;
    assign dp.clr   = clr_q;

`ifdef STOP_WATCH_CTRL_LAP_EN
    logic       lap_p;
    logic       unused_lap_level;
    logic [3:0] lap2_q, lap1_q, lap0_q;
    logic       lap_valid_q;

    btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_lap (
        .clk(clk), .reset(reset), .btn_raw(btn_lap),
        .level(unused_lap_level), .rise_p(lap_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap2_q      <= '0;
            lap1_q      <= '0;
            lap0_q      <= '0;
            lap_valid_q <= 1'b0;
        end else if (clr_p) begin
            lap2_q      <= '0;
            lap1_q      <= '0;
            lap0_q      <= '0;
            lap_valid_q <= 1'b0;
        end else if (lap_p && (state_q == RUN || state_q == PAUSE)) begin
            lap2_q      <= dp.d2;
            lap1_q      <= dp.d1;
            lap0_q      <= dp.d0;
            lap_valid_q <= 1'b1;
        end
    end

    assign dp.lap_d2    = lap2_q;
    assign dp.lap_d1    = lap1_q;
    assign dp.lap_d0    = lap0_q;
    assign dp.lap_valid = lap_valid_q;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;

    assign dp.lap_d2    = '0;
    assign dp.lap_d1    = '0;
    assign dp.lap_d0    = '0;
    assign dp.lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Self-checking bench for stop_watch_ctrl: two DUTs (MAX_STOP=1 / MAX_STOP=0) share stimulus.
// Lap expectations follow STOP_WATCH_CTRL_LAP_EN as seen by this compilation.
module tb_stop_watch_ctrl;
    localparam int unsigned DB = 4;
`ifdef STOP_WATCH_CTRL_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_go = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
    logic [3:0] d2 = '0, d1 = '0, d0 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stop_watch_ctrl_if ifa ();
    stop_watch_ctrl_if ifb ();
    assign ifa.d2 = d2;
    assign ifa.d1 = d1;
    assign ifa.d0 = d0;
    assign ifb.d2 = d2;
    assign ifb.d1 = d1;
    assign ifb.d0 = d0;

    stop_watch_ctrl #(.DB_TICKS(DB), .MAX_STOP(1'b1)) u_dut_stop (
        .clk(clk), .reset(rst), .btn_go(btn_go), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .dp(ifa)
    );

    stop_watch_ctrl #(.DB_TICKS(DB), .MAX_STOP(1'b0)) u_dut_wrap (
        .clk(clk), .reset(rst), .btn_go(btn_go), .btn_clr(btn_clr),
        .btn_lap(btn_lap), .dp(ifb)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int st;   // 0 idle, 1 run, 2 pause, 3 done
        int go;
        int clr;
        int lap;  // captured reading as a decimal number
        int lv;
    } mdl_t;

    mdl_t ma, mb;
    bit   hist [3][DB+1];  // raw samples, [0] = most recent edge
    bit   mlvl [3];
    bit   pend [3];        // accepted rising edges, acted on at the next edge

    function automatic mdl_t fsm_step(mdl_t m, bit c, bit g, bit l, int dv, bit ms);
        mdl_t n = m;
        n.clr = 0;
        if (c) begin
            n.st = 0; n.clr = 1; n.lap = 0; n.lv = 0;
        end else begin
            if (LAP_EN && l && (m.st == 1 || m.st == 2)) begin
                n.lap = dv; n.lv = 1;
            end
            if (m.st == 0 && g) n.st = 1;
            else if (m.st == 1 && g) n.st = 2;
            else if (m.st == 1 && ms && dv == 999) n.st = 3;
            else if (m.st == 2 && g) n.st = 1;
        end
        n.go = (n.st == 1) ? 1 : 0;
        return n;
    endfunction

    task automatic mreset();
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        for (int b = 0; b < 3; b++) begin
            mlvl[b] = 0;
            pend[b] = 0;
            for (int j = 0; j <= DB; j++) hist[b][j] = 0;
        end
    endtask

    task automatic mstep();
        bit raw [3];
        bit all;
        int dv;
        dv = int'(d2) * 100 + int'(d1) * 10 + int'(d0);
        raw[0] = btn_go; raw[1] = btn_clr; raw[2] = btn_lap;
        ma = fsm_step(ma, pend[1], pend[0], pend[2], dv, 1'b1);
        mb = fsm_step(mb, pend[1], pend[0], pend[2], dv, 1'b0);
        // accepted level flips once the DB samples two edges back all disagree with it
        for (int b = 0; b < 3; b++) begin
            all = 1;
            for (int j = 1; j <= DB; j++) if (hist[b][j] == mlvl[b]) all = 0;
            pend[b] = 0;
            if (all) begin
                mlvl[b] = ~mlvl[b];
                pend[b] = mlvl[b];
            end
            if (b == 2 && !LAP_EN) pend[b] = 0;
            for (int j = DB; j >= 1; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) mreset();
            else mstep();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int lap_a();
        return int'(ifa.lap_d2) * 100 + int'(ifa.lap_d1) * 10 + int'(ifa.lap_d0);
    endfunction

    function automatic int lap_b();
        return int'(ifb.lap_d2) * 100 + int'(ifb.lap_d1) * 10 + int'(ifb.lap_d0);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            chk("a.state", int'(ifa.state), ma.st);
            chk("a.go", int'(ifa.go), ma.go);
            chk("a.clr", int'(ifa.clr), ma.clr);
            chk("a.lap", lap_a(), ma.lap);
            chk("a.lap_valid", int'(ifa.lap_valid), ma.lv);
            chk("b.state", int'(ifb.state), mb.st);
            chk("b.go", int'(ifb.go), mb.go);
            chk("b.clr", int'(ifb.clr), mb.clr);
            chk("b.lap", lap_b(), mb.lap);
            chk("b.lap_valid", int'(ifb.lap_valid), mb.lv);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int which, input int hold);
        if (which == 0) btn_go = 1'b1;
        else if (which == 1) btn_clr = 1'b1;
        else btn_lap = 1'b1;
        tick(hold);
        btn_go = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        tick(8);
    endtask

    initial begin
        int hold [3];
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("lit.reset_state", int'(ifa.state), 0);
        chk("lit.reset_go", int'(ifa.go), 0);
        chk("lit.reset_clr", int'(ifa.clr), 0);
        chk("lit.reset_lap_valid", int'(ifa.lap_valid), 0);

        // 3-cycle glitch is rejected
        btn_go = 1'b1; tick(3); btn_go = 1'b0; tick(10);
        chk("lit.glitch_state", int'(ifa.state), 0);

        // held press: RUN exactly 7 edges after the press
        btn_go = 1'b1;
        tick(6);
        chk("lit.press_edge6", int'(ifa.state), 0);
        tick(1);
        chk("lit.press_edge7_state", int'(ifa.state), 1);
        chk("lit.press_edge7_go", int'(ifa.go), 1);
        tick(3); btn_go = 1'b0; tick(8);

        press(0, 8);
        chk("lit.pause_state", int'(ifa.state), 2);
        chk("lit.pause_go", int'(ifa.go), 0);
        press(0, 8);
        chk("lit.resume_state", int'(ifa.state), 1);

        press(0, 100);
        chk("lit.long_hold_state", int'(ifa.state), 2);
        press(0, 8);

        d2 = 4; d1 = 2; d0 = 7;
        press(2, 8);
        chk("lit.lap_digits", lap_a(), LAP_EN ? 427 : 0);
        chk("lit.lap_valid", int'(ifa.lap_valid), LAP_EN ? 1 : 0);

        d2 = 9; d1 = 9; d0 = 8; tick(1);
        d0 = 9; tick(1);
        d2 = 0; d1 = 0; d0 = 0;
        chk("lit.autostop_state", int'(ifa.state), 3);
        chk("lit.autostop_go", int'(ifa.go), 0);
        chk("lit.wrap_state", int'(ifb.state), 1);
        press(0, 8);
        chk("lit.done_ignores_go", int'(ifa.state), 3);

        btn_clr = 1'b1; tick(7);
        chk("lit.clr_pulse", int'(ifa.clr), 1);
        chk("lit.clr_state", int'(ifa.state), 0);
        chk("lit.clr_lap_valid", int'(ifa.lap_valid), 0);
        tick(1);
        chk("lit.clr_one_cycle", int'(ifa.clr), 0);
        btn_clr = 1'b0; tick(8);

        press(2, 8);
        chk("lit.idle_lap_ignored", int'(ifa.lap_valid), 0);

        press(0, 8);
        btn_clr = 1'b1; btn_go = 1'b1; tick(7);
        chk("lit.clr_beats_go_clr", int'(ifa.clr), 1);
        chk("lit.clr_beats_go_state", int'(ifa.state), 0);
        chk("lit.clr_beats_go_go", int'(ifa.go), 0);
        tick(1); btn_clr = 1'b0; btn_go = 1'b0; tick(8);

        press(0, 8);
        d2 = 1; d1 = 5; d0 = 3;
        btn_go = 1'b1; btn_lap = 1'b1; tick(8);
        btn_go = 1'b0; btn_lap = 1'b0; tick(8);
        chk("lit.go_lap_state", int'(ifa.state), 2);
        chk("lit.go_lap_digits", lap_a(), LAP_EN ? 153 : 0);

        // asynchronous reset in the middle of RUN
        press(0, 8);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("lit.async_state", int'(ifa.state), 0);
        chk("lit.async_go", int'(ifa.go), 0);
        chk("lit.async_lap_valid", int'(ifa.lap_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        tick(10);
        chk("lit.after_reset_state", int'(ifa.state), 0);

        // randomized phase
        hold[0] = 0; hold[1] = 0; hold[2] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (hold[0] == 0) begin
                btn_go = ($urandom_range(0, 1) == 1);
                hold[0] = $urandom_range(1, 14);
            end
            if (hold[1] == 0) begin
                btn_clr = ($urandom_range(0, 7) == 0);
                hold[1] = $urandom_range(1, 14);
            end
            if (hold[2] == 0) begin
                btn_lap = ($urandom_range(0, 2) == 0);
                hold[2] = $urandom_range(1, 14);
            end
            for (int b = 0; b < 3; b++) hold[b]--;
            if ($urandom_range(0, 15) == 0) begin
                d2 = 9; d1 = 9; d0 = 9;
            end else begin
                d2 = 4'($urandom_range(0, 9));
                d1 = 4'($urandom_range(0, 9));
                d0 = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end else begin
                tick(1);
            end
        end

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
